// File: rtl/instr_mem_loadable.sv
// Byte-addressed instruction memory with a byte-serial program-load port and
// a registered fetch port that flags misaligned or out-of-range fetches.
module instr_mem_loadable #(
  parameter int DEPTH      = 16,
  parameter int WIDTH      = 16,
  parameter int BPW        = 2,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [7:0]            load_byte,
  input  logic                  load_valid,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  load_done,
  output logic                  busy,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  fetch_en,
  output logic [WIDTH-1:0]      instruction,
  output logic                  instr_valid,
  output logic                  fault,
  output logic [1:0]            fsm_state
);

  localparam int NBYTES = DEPTH * BPW;
  localparam int PTR_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int OFF_W  = $clog2(BPW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [7:0]       mem [NBYTES];

  // Load handshake: a byte transfers when load_valid is high while load_ready
  // is high (LOAD state); load_start in the same cycle wins and drops the byte.
  logic accept;
  logic finish;
  assign accept = (state == LOAD) && load_valid && !load_start;
  assign finish = accept && (load_last || (ptr == PTR_W'(NBYTES - 1)));

  // Byte-wide storage so a partial final word only touches delivered lanes.
  always_ff @(posedge clk) begin
    if (accept) mem[ptr] <= load_byte;
  end

  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  misaligned;
  logic                  out_of_range;
  logic [WIDTH-1:0]      rd_word;

  assign word_idx     = pc >> OFF_W;
  assign misaligned   = (pc & ADDR_WIDTH'(BPW - 1)) != '0;
  assign out_of_range = int'(word_idx) >= DEPTH;

  // Big-endian assembly: byte lane 0 lands in the most significant byte.
  always_comb begin
    rd_word = '0;
    if (!out_of_range) begin
      for (int l = 0; l < BPW; l++) begin
        rd_word[WIDTH-1-8*l -: 8] = mem[PTR_W'(int'(word_idx) * BPW + l)];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      load_ready  <= 1'b0;
      load_done   <= 1'b0;
      busy        <= 1'b0;
      instruction <= '0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
    end else begin
      load_done   <= 1'b0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            state      <= LOAD;
            ptr        <= '0;
            load_ready <= 1'b1;
            busy       <= 1'b1;
          end
        end
        LOAD: begin
          if (load_start) begin
            ptr <= '0;
          end else if (finish) begin
            state      <= RUN;
            ptr        <= '0;
            load_ready <= 1'b0;
            busy       <= 1'b0;
            load_done  <= 1'b1;
          end else if (accept) begin
            ptr <= ptr + PTR_W'(1);
          end
        end
        RUN: begin
          if (load_start) begin
            state      <= LOAD;
            ptr        <= '0;
            load_ready <= 1'b1;
            busy       <= 1'b1;
          end else if (fetch_en) begin
            if (misaligned || out_of_range) begin
              instruction <= '0;
              fault       <= 1'b1;
            end else begin
              instruction <= rd_word;
              instr_valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Randomised bench for instr_mem_loadable: a byte-array reference model feeds an
// expected-fetch queue that a negedge monitor drains whenever the DUT reports.
module tb_instr_mem_loadable;

  localparam int DEPTH = 16;
  localparam int WIDTH = 16;
  localparam int BPW   = 2;
  localparam int AW    = 5;
  localparam int NB    = DEPTH * BPW;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_start = 1'b0;
  logic [7:0]    load_byte = 8'h00;
  logic          load_valid = 1'b0;
  logic          load_last = 1'b0;
  logic [AW-1:0] pc = '0;
  logic          fetch_en = 1'b0;

  logic             load_ready, load_done, busy, instr_valid, fault;
  logic [WIDTH-1:0] instruction;
  logic [1:0]       fsm_state;

  logic             s_load_ready, s_load_done, s_busy, s_instr_valid, s_fault;
  logic [WIDTH-1:0] s_instruction;
  logic [1:0]       s_fsm_state;

  instr_mem_loadable #(.DEPTH(DEPTH), .WIDTH(WIDTH), .BPW(BPW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_byte(load_byte),
    .load_valid(load_valid), .load_last(load_last), .load_ready(load_ready),
    .load_done(load_done), .busy(busy), .pc(pc), .fetch_en(fetch_en),
    .instruction(instruction), .instr_valid(instr_valid), .fault(fault),
    .fsm_state(fsm_state)
  );

  // Smaller instance sharing all inputs, used for the out-of-range case.
  instr_mem_loadable #(.DEPTH(12), .WIDTH(WIDTH), .BPW(BPW), .ADDR_WIDTH(AW)) dut12 (
    .clk(clk), .reset(reset), .load_start(load_start), .load_byte(load_byte),
    .load_valid(load_valid), .load_last(load_last), .load_ready(s_load_ready),
    .load_done(s_load_done), .busy(s_busy), .pc(pc), .fetch_en(fetch_en),
    .instruction(s_instruction), .instr_valid(s_instr_valid), .fault(s_fault),
    .fsm_state(s_fsm_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int mode = M_IDLE;

  logic [WIDTH:0] exp_q[$];
  logic [7:0]     ref_mem [NB];
  logic [7:0]     img [NB];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {fault, word} for a byte address, straight from the address rules.
  function automatic logic [WIDTH:0] model_fetch(input logic [AW-1:0] a);
    int idx;
    idx = int'(a) / BPW;
    if ((int'(a) % BPW) != 0 || idx >= DEPTH) return {1'b1, 16'h0000};
    return {1'b0, ref_mem[idx*BPW], ref_mem[idx*BPW+1]};
  endfunction

  task automatic issue_fetch(input logic [AW-1:0] a);
    pc = a;
    fetch_en = 1'b1;
    if (mode == M_RUN && !load_start) exp_q.push_back(model_fetch(a));
    tick();
    fetch_en = 1'b0;
  endtask

  task automatic load_image(input int n, input bit use_last, input bit gaps);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    mode = M_LOAD;
    check("load_ready_in_load", {31'd0, load_ready}, 32'd1);
    check("busy_in_load", {31'd0, busy}, 32'd1);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        load_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      load_valid = 1'b1;
      load_byte  = img[i];
      load_last  = use_last && (i == n - 1);
      ref_mem[i] = img[i];
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    mode = M_RUN;
    exp_done++;
    check("busy_after_load", {31'd0, busy}, 32'd0);
    check("ready_after_load", {31'd0, load_ready}, 32'd0);
    check("state_run", {30'd0, fsm_state}, 32'd2);
    tick();
    tick();
    check("load_done_count", done_cnt, exp_done);
  endtask

  // Monitor: pop one expectation per reported fetch result.
  initial begin
    logic [WIDTH:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (load_done) done_cnt++;
        if (instr_valid || fault) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_fetch_output: valid=%0b fault=%0b instr=%0h, expected no output",
                     instr_valid, fault, instruction);
          end else begin
            e = exp_q.pop_front();
            if (e[WIDTH])
              check("bad_fetch", {14'd0, instr_valid, fault, instruction}, {14'd0, 2'b01, 16'h0000});
            else
              check("good_fetch", {14'd0, instr_valid, fault, instruction}, {14'd0, 2'b10, e[WIDTH-1:0]});
          end
        end
      end
    end
  end

  // Driver
  initial begin
    int n;
    bit ul;
    #12;
    check("rst_load_ready", {31'd0, load_ready}, 32'd0);
    check("rst_load_done", {31'd0, load_done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_outputs", {14'd0, instr_valid, fault, instruction}, 32'd0);
    check("rst_state", {30'd0, fsm_state}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    issue_fetch(5'd0);
    check("idle_fetch_ignored", {30'd0, instr_valid, fault}, 32'd0);

    for (int i = 0; i < NB; i++) img[i] = 8'(i);
    load_image(NB, 1'b0, 1'b0);
    check("small_state_run", {30'd0, s_fsm_state}, 32'd2);

    issue_fetch(5'd0);
    tick();
    issue_fetch(5'd30);
    tick();
    for (int k = 0; k < DEPTH; k++) issue_fetch(AW'(2 * k));
    issue_fetch(5'd3);
    check("misaligned_nop", {14'd0, instr_valid, fault, instruction}, {14'd0, 2'b01, 16'h0000});

    issue_fetch(5'd24);
    check("small_out_of_range", {14'd0, s_instr_valid, s_fault, s_instruction}, {14'd0, 2'b01, 16'h0000});
    issue_fetch(5'd22);
    check("small_last_word", {14'd0, s_instr_valid, s_fault, s_instruction}, {14'd0, 2'b10, 16'h1617});
    tick();
    check("hold_instruction", {14'd0, instr_valid, fault, instruction}, {14'd0, 2'b00, 16'h1617});

    img[0] = 8'hAA; img[1] = 8'hBB; img[2] = 8'hCC;
    load_image(3, 1'b1, 1'b0);
    issue_fetch(5'd0);
    issue_fetch(5'd2);
    check("partial_lane", {16'd0, instruction}, 32'h0000CC03);
    issue_fetch(5'd4);
    check("old_contents", {16'd0, instruction}, 32'h00000405);

    // Load request collides with a fetch; then restart and reset mid-load.
    pc = 5'd0;
    fetch_en = 1'b1;
    load_start = 1'b1;
    tick();
    fetch_en = 1'b0;
    load_start = 1'b0;
    mode = M_LOAD;
    check("collision_no_output", {30'd0, instr_valid, fault}, 32'd0);
    load_valid = 1'b1;
    load_byte = 8'h11; ref_mem[0] = 8'h11; tick();
    load_byte = 8'h22; ref_mem[1] = 8'h22; tick();
    load_start = 1'b1;
    load_byte = 8'h77;
    tick();
    load_start = 1'b0;
    load_byte = 8'h33; ref_mem[0] = 8'h33; tick();
    load_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("midload_reset_busy", {31'd0, busy}, 32'd0);
    check("midload_reset_state", {30'd0, fsm_state}, 32'd0);
    mode = M_IDLE;
    @(negedge clk);
    reset = 1'b0;
    tick();
    issue_fetch(5'd0);
    check("fetch_after_reset_ignored", {30'd0, instr_valid, fault}, 32'd0);
    img[0] = 8'h44;
    load_image(1, 1'b1, 1'b0);
    issue_fetch(5'd0);
    check("retained_lane", {16'd0, instruction}, 32'h00004422);
    issue_fetch(5'd2);
    check("restart_no_write", {16'd0, instruction}, 32'h0000CC03);

    repeat (4) begin
      n = $urandom_range(1, NB);
      ul = (n < NB) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) img[i] = 8'($urandom);
      load_image(n, ul, 1'b1);
      repeat (40) begin
        if ($urandom_range(0, 3) == 0) tick();
        else issue_fetch(AW'($urandom_range(0, 31)));
      end
    end

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
